vram_arbiter: RTL and testbench

- Shares the single-port video RAM between the display pixel-fetch path and a host write port.
- Sits between the horizontal/vertical timing state machines, the pixel fetch logic and the VRAM macro.
- Inside the visible window (horizontal AND vertical active video), the display owns the RAM exclusively.
- Outside the window, the display still has priority, and host writes drain from a small posted-write FIFO.

---
 rtl/vram_arbiter.sv | 159 +++++++++++++++
 tb/tb_vram_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port video RAM between the display fetch
// path and a host write port. The display always wins when it asks.
// Host writes are queued in a small posted-write FIFO and drain only
// outside the visible window.
module vram_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        horizontal_active_video_i,
  input  logic                        vertical_active_video_i,
  input  logic                        disp_req_i,
  input  logic [ADDR_WIDTH-1:0]       disp_addr_i,
  output logic [DATA_WIDTH-1:0]       disp_data_o,
  output logic                        disp_valid_o,
  input  logic                        host_wr_valid_i,
  output logic                        host_wr_ready_o,
  input  logic [ADDR_WIDTH-1:0]       host_wr_addr_i,
  input  logic [DATA_WIDTH-1:0]       host_wr_data_i,
  output logic                        ram_en_o,
  output logic                        ram_we_o,
  output logic [ADDR_WIDTH-1:0]       ram_addr_o,
  output logic [DATA_WIDTH-1:0]       ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]       ram_rdata_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int LVL_WIDTH = PTR_WIDTH + 1;
  localparam logic [LVL_WIDTH-1:0] FULL_LEVEL = LVL_WIDTH'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_DISP = 2'd1,
    ARB_HOST = 2'd2
  } arb_state_t;

  arb_state_t            state_reg;
  logic                  ram_en_reg;
  logic                  ram_we_reg;
  logic [ADDR_WIDTH-1:0] ram_addr_reg;
  logic [DATA_WIDTH-1:0] ram_wdata_reg;
  logic                  disp_valid_reg;
  logic [DATA_WIDTH-1:0] disp_hold_reg;

  logic [PTR_WIDTH-1:0]  wr_ptr_reg;
  logic [PTR_WIDTH-1:0]  rd_ptr_reg;
  logic [LVL_WIDTH-1:0]  level_reg;

  logic [ADDR_WIDTH-1:0] slot_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] slot_data [FIFO_DEPTH];

  logic window;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic grant_disp;
  logic grant_host;

  assign window     = horizontal_active_video_i & vertical_active_video_i;
  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == FULL_LEVEL);

  // Ready comes from the registered level only, so a pop on a full FIFO
  // re-opens the port one cycle later rather than allowing push-through.
  assign host_wr_ready_o = !rst_i && !fifo_full;
  assign push            = host_wr_valid_i & host_wr_ready_o;

  // Display has absolute priority; the host only drains during blanking.
  assign grant_disp = disp_req_i;
  assign grant_host = !disp_req_i && !window && !fifo_empty;

  // Posted-write storage: one slot register set per FIFO entry.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_slot
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] data_reg;

    // Capture an accepted host write when the write pointer points here
    always_ff @(posedge clk_i) begin
      if (push && (wr_ptr_reg == PTR_WIDTH'(gi))) begin
        addr_reg <= host_wr_addr_i;
        data_reg <= host_wr_data_i;
      end
    end

    assign slot_addr[gi] = addr_reg;
    assign slot_data[gi] = data_reg;
  end

  // FIFO pointers and occupancy; pop coincides with the host grant decision
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_WIDTH'(1);
      end
      if (grant_host) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_WIDTH'(1);
      end
      case ({push, grant_host})
        2'b10:   level_reg <= level_reg + LVL_WIDTH'(1);
        2'b01:   level_reg <= level_reg - LVL_WIDTH'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Arbiter FSM: the state and RAM strobes describe the access issued next cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= ARB_IDLE;
      ram_en_reg     <= 1'b0;
      ram_we_reg     <= 1'b0;
      ram_addr_reg   <= '0;
      ram_wdata_reg  <= '0;
      disp_valid_reg <= 1'b0;
      disp_hold_reg  <= '0;
    end else begin
      // A display read in flight this cycle returns its word next cycle.
      disp_valid_reg <= (state_reg == ARB_DISP);
      if (disp_valid_reg) begin
        disp_hold_reg <= ram_rdata_i;
      end
      if (grant_disp) begin
        state_reg    <= ARB_DISP;
        ram_en_reg   <= 1'b1;
        ram_we_reg   <= 1'b0;
        ram_addr_reg <= disp_addr_i;
      end else if (grant_host) begin
        state_reg     <= ARB_HOST;
        ram_en_reg    <= 1'b1;
        ram_we_reg    <= 1'b1;
        ram_addr_reg  <= slot_addr[rd_ptr_reg];
        ram_wdata_reg <= slot_data[rd_ptr_reg];
      end else begin
        state_reg  <= ARB_IDLE;
        ram_en_reg <= 1'b0;
        ram_we_reg <= 1'b0;
      end
    end
  end

  assign ram_en_o     = ram_en_reg;
  assign ram_we_o     = ram_we_reg;
  assign ram_addr_o   = ram_addr_reg;
  assign ram_wdata_o  = ram_wdata_reg;
  assign disp_valid_o = disp_valid_reg;
  assign fifo_level_o = level_reg;

  // The RAM's own output register supplies the word in the valid cycle;
  // outside valid cycles the last delivered word is held.
  assign disp_data_o = disp_valid_reg ? ram_rdata_i : disp_hold_reg;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based behavioural model of the arbiter and a RAM model.
module tb_vram_arbiter;

  localparam int AW = 17;
  localparam int DW = 8;
  localparam int D  = 4;
  localparam int LW = 3;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_i = 1'b1;
  logic          h_act = 1'b0;
  logic          v_act = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          wv = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] ram_rdata = '0;

  logic [DW-1:0] disp_data_o;
  logic          disp_valid_o;
  logic          host_wr_ready_o;
  logic          ram_en_o;
  logic          ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o;
  logic [LW-1:0] fifo_level_o;

  vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
    .clk_i                     (clk_i),
    .rst_i                     (rst_i),
    .horizontal_active_video_i (h_act),
    .vertical_active_video_i   (v_act),
    .disp_req_i                (disp_req),
    .disp_addr_i               (disp_addr),
    .disp_data_o               (disp_data_o),
    .disp_valid_o              (disp_valid_o),
    .host_wr_valid_i           (wv),
    .host_wr_ready_o           (host_wr_ready_o),
    .host_wr_addr_i            (waddr),
    .host_wr_data_i            (wdata),
    .ram_en_o                  (ram_en_o),
    .ram_we_o                  (ram_we_o),
    .ram_addr_o                (ram_addr_o),
    .ram_wdata_o               (ram_wdata_o),
    .ram_rdata_i               (ram_rdata),
    .fifo_level_o              (fifo_level_o)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Environment RAM and the model's own view of RAM contents
  logic [DW-1:0] ram_mem [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  wr_t           wr_log[$];

  function automatic logic [DW-1:0] def_val(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 8'hA5;
  endfunction

  // RAM model: sample the request mid-cycle, act on the following edge
  logic          r_en = 1'b0;
  logic          r_we = 1'b0;
  logic [AW-1:0] r_addr = '0;
  logic [DW-1:0] r_wdata = '0;

  always @(negedge clk_i) begin
    r_en    = (ram_en_o === 1'b1);
    r_we    = (ram_we_o === 1'b1);
    r_addr  = ram_addr_o;
    r_wdata = ram_wdata_o;
    if (r_en)
      $display("%0t ram %s addr=%05h wdata=%02h", $time, r_we ? "wr" : "rd", r_addr, r_wdata);
  end

  always @(posedge clk_i) begin
    if (r_en) begin
      if (r_we) begin
        ram_mem[r_addr] = r_wdata;
        wr_log.push_back(wr_t'({r_addr, r_wdata}));
      end else begin
        ram_rdata <= ram_mem.exists(r_addr) ? ram_mem[r_addr] : def_val(r_addr);
      end
    end
  end

  // Behavioural model: m_* are the outputs expected after each edge
  logic          m_en = 1'b0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [LW-1:0] m_level = '0;
  wr_t           mq[$];

  always @(posedge clk_i) begin
    logic          rd_now;
    logic [DW-1:0] rd_word;
    logic          acc;
    wr_t           e;
    rd_now  = m_en && !m_we;
    rd_word = ref_mem.exists(m_addr) ? ref_mem[m_addr] : def_val(m_addr);
    if (m_en && m_we) ref_mem[m_addr] = m_wdata;
    if (rst_i) begin
      mq.delete();
      m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      m_valid = 1'b0; m_data = '0; m_level = '0;
    end else begin
      m_valid = rd_now;
      if (rd_now) m_data = rd_word;
      acc = wv && (mq.size() < D);
      if (disp_req) begin
        m_en = 1'b1; m_we = 1'b0; m_addr = disp_addr;
      end else if (!(h_act && v_act) && mq.size() > 0) begin
        e = mq.pop_front();
        m_en = 1'b1; m_we = 1'b1; m_addr = e.a; m_wdata = e.d;
      end else begin
        m_en = 1'b0; m_we = 1'b0;
      end
      if (acc) mq.push_back(wr_t'({waddr, wdata}));
      m_level = LW'(mq.size());
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    h_act = 1'b0; v_act = 1'b0; disp_req = 1'b0; disp_addr = '0;
    wv = 1'b0; waddr = '0; wdata = '0;
  endtask

  task automatic apply_reset(input int n);
    rst_i = 1'b1;
    repeat (n) next_cycle();
    rst_i = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ram_mem[a] = d;
    ref_mem[a] = d;
  endtask

  // Reset holds the write port closed and keeps the RAM idle
  task automatic test_reset();
    idle_inputs();
    wv = 1'b1; waddr = 17'h00001; wdata = 8'h11; disp_req = 1'b1;
    rst_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clk_i);
      n_checks++; if (host_wr_ready_o !== 1'b0) $display("FAIL reset_ready c%0d: got %b want 0", c, host_wr_ready_o); else n_pass++;
      n_checks++; if (fifo_level_o !== 3'd0) $display("FAIL reset_level c%0d: got %0d want 0", c, fifo_level_o); else n_pass++;
      n_checks++; if (ram_en_o !== 1'b0) $display("FAIL reset_ram_en c%0d: got %b want 0", c, ram_en_o); else n_pass++;
      n_checks++; if (disp_valid_o !== 1'b0) $display("FAIL reset_valid c%0d: got %b want 0", c, disp_valid_o); else n_pass++;
    end
    next_cycle();
    rst_i = 1'b0; wv = 1'b0; disp_req = 1'b0;
    @(negedge clk_i);
    n_checks++; if (fifo_level_o !== 3'd0) $display("FAIL reset_no_push: level got %0d want 0", fifo_level_o); else n_pass++;
    n_checks++; if (host_wr_ready_o !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", host_wr_ready_o); else n_pass++;
    n_checks++; if ({ram_addr_o, ram_wdata_o, disp_data_o} !== '0) $display("FAIL reset_outputs: got %h/%h/%h want 0", ram_addr_o, ram_wdata_o, disp_data_o); else n_pass++;
  endtask

  // Request in N -> RAM cycle in N+1 -> valid word in N+2 only
  task automatic test_disp_latency();
    apply_reset(2);
    idle_inputs();
    h_act = 1'b1; v_act = 1'b1;
    preload(17'h00123, 8'h5A);
    next_cycle();
    disp_req = 1'b1; disp_addr = 17'h00123;
    @(negedge clk_i);
    n_checks++; if (ram_en_o !== 1'b0) $display("FAIL lat_n_en: got %b want 0", ram_en_o); else n_pass++;
    next_cycle();
    disp_req = 1'b0; disp_addr = 17'h1FFFF;
    @(negedge clk_i);
    n_checks++; if ({ram_en_o, ram_we_o, ram_addr_o} !== {1'b1, 1'b0, 17'h00123}) $display("FAIL lat_n1_ram: got en=%b we=%b addr=%05h want 1/0/00123", ram_en_o, ram_we_o, ram_addr_o); else n_pass++;
    n_checks++; if (disp_valid_o !== 1'b0) $display("FAIL lat_n1_valid: got %b want 0", disp_valid_o); else n_pass++;
    next_cycle();
    @(negedge clk_i);
    n_checks++; if ({disp_valid_o, disp_data_o} !== {1'b1, 8'h5A}) $display("FAIL lat_n2_data: got v=%b d=%02h want 1/5a", disp_valid_o, disp_data_o); else n_pass++;
    n_checks++; if (ram_en_o !== 1'b0) $display("FAIL lat_n2_en: got %b want 0", ram_en_o); else n_pass++;
    next_cycle();
    @(negedge clk_i);
    n_checks++; if ({disp_valid_o, disp_data_o} !== {1'b0, 8'h5A}) $display("FAIL lat_n3_hold: got v=%b d=%02h want 0/5a", disp_valid_o, disp_data_o); else n_pass++;
  endtask

  // Host writes wait for the window to close, then drain in order
  task automatic test_window_lockout();
    apply_reset(2);
    idle_inputs();
    h_act = 1'b1; v_act = 1'b1;
    wv = 1'b1; waddr = 17'h00010; wdata = 8'hAA;
    next_cycle();
    waddr = 17'h00011; wdata = 8'hBB;
    next_cycle();
    wv = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_checks++; if ({ram_we_o, fifo_level_o} !== {1'b0, 3'd2}) $display("FAIL lock_hold c%0d: got we=%b lvl=%0d want 0/2", c, ram_we_o, fifo_level_o); else n_pass++;
      next_cycle();
    end
    h_act = 1'b0;
    @(negedge clk_i);
    n_checks++; if ({ram_en_o, fifo_level_o} !== {1'b0, 3'd2}) $display("FAIL lock_drop: got en=%b lvl=%0d want 0/2", ram_en_o, fifo_level_o); else n_pass++;
    next_cycle();
    @(negedge clk_i);
    n_checks++; if ({ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, fifo_level_o} !== {2'b11, 17'h00010, 8'hAA, 3'd1})
      $display("FAIL lock_wr1: got en=%b we=%b a=%05h d=%02h lvl=%0d want 1/1/00010/aa/1", ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, fifo_level_o); else n_pass++;
    next_cycle();
    @(negedge clk_i);
    n_checks++; if ({ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, fifo_level_o} !== {2'b11, 17'h00011, 8'hBB, 3'd0})
      $display("FAIL lock_wr2: got en=%b we=%b a=%05h d=%02h lvl=%0d want 1/1/00011/bb/0", ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, fifo_level_o); else n_pass++;
    next_cycle();
    @(negedge clk_i);
    n_checks++; if (ram_en_o !== 1'b0) $display("FAIL lock_done: got en=%b want 0", ram_en_o); else n_pass++;
  endtask

  // During blanking the display still pre-empts a pending host write
  task automatic test_blanking_priority();
    apply_reset(2);
    idle_inputs();
    h_act = 1'b1; v_act = 1'b1;
    wv = 1'b1; waddr = 17'h00020; wdata = 8'hCC;
    next_cycle();
    wv = 1'b0; h_act = 1'b0; v_act = 1'b0;
    for (int k = 0; k < 4; k++) begin
      disp_req  = (k < 3);
      disp_addr = AW'(17'h00030 + k);
      @(negedge clk_i);
      if (k == 0) begin
        n_checks++; if ({ram_en_o, fifo_level_o} !== {1'b0, 3'd1}) $display("FAIL prio_start: got en=%b lvl=%0d want 0/1", ram_en_o, fifo_level_o); else n_pass++;
      end else begin
        n_checks++; if ({ram_en_o, ram_we_o, ram_addr_o, fifo_level_o} !== {2'b10, AW'(17'h00030 + k - 1), 3'd1})
          $display("FAIL prio_rd%0d: got en=%b we=%b a=%05h lvl=%0d want 1/0/%05h/1", k, ram_en_o, ram_we_o, ram_addr_o, fifo_level_o, AW'(17'h00030 + k - 1)); else n_pass++;
      end
      next_cycle();
    end
    @(negedge clk_i);
    n_checks++; if ({ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, fifo_level_o} !== {2'b11, 17'h00020, 8'hCC, 3'd0})
      $display("FAIL prio_host: got en=%b we=%b a=%05h d=%02h lvl=%0d want 1/1/00020/cc/0", ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, fifo_level_o); else n_pass++;
  endtask

  // Four accepts fill the FIFO; the fifth waits for a pop, all land in order
  task automatic test_full_backpressure();
    int idx;
    apply_reset(2);
    idle_inputs();
    h_act = 1'b1; v_act = 1'b1;
    wr_log.delete();
    idx = 0;
    wv = 1'b1;
    for (int c = 0; c < 6; c++) begin
      waddr = AW'(17'h00040 + idx); wdata = DW'(8'h60 + idx);
      @(negedge clk_i);
      n_checks++; if ({host_wr_ready_o, fifo_level_o} !== {(c < 4), LW'((c < 4) ? c : 4)})
        $display("FAIL full_fill c%0d: got rdy=%b lvl=%0d want %b/%0d", c, host_wr_ready_o, fifo_level_o, (c < 4), (c < 4) ? c : 4); else n_pass++;
      if (host_wr_ready_o === 1'b1) idx++;
      next_cycle();
    end
    h_act = 1'b0;
    @(negedge clk_i);
    n_checks++; if ({host_wr_ready_o, fifo_level_o} !== {1'b0, 3'd4}) $display("FAIL full_pop_cycle: got rdy=%b lvl=%0d want 0/4", host_wr_ready_o, fifo_level_o); else n_pass++;
    next_cycle();
    @(negedge clk_i);
    n_checks++; if ({host_wr_ready_o, fifo_level_o} !== {1'b1, 3'd3}) $display("FAIL full_ready_rise: got rdy=%b lvl=%0d want 1/3", host_wr_ready_o, fifo_level_o); else n_pass++;
    next_cycle();
    wv = 1'b0;
    repeat (8) next_cycle();
    n_checks++; if (wr_log.size() != 5) $display("FAIL full_count: got %0d writes want 5", wr_log.size()); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      if (k < wr_log.size()) begin
        n_checks++; if (wr_log[k] !== wr_t'({AW'(17'h00040 + k), DW'(8'h60 + k)}))
          $display("FAIL full_order%0d: got %05h<-%02h want %05h<-%02h", k, wr_log[k].a, wr_log[k].d, AW'(17'h00040 + k), DW'(8'h60 + k)); else n_pass++;
      end
    end
  endtask

  // Reset cuts a read in flight and discards queued writes
  task automatic test_reset_midstream();
    apply_reset(2);
    idle_inputs();
    h_act = 1'b1; v_act = 1'b1;
    wv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      waddr = AW'(17'h00070 + k); wdata = DW'(8'h80 + k);
      next_cycle();
    end
    wv = 1'b0; disp_req = 1'b1; disp_addr = 17'h00050;
    @(negedge clk_i);
    n_checks++; if (fifo_level_o !== 3'd3) $display("FAIL mid_level: got %0d want 3", fifo_level_o); else n_pass++;
    next_cycle();
    disp_req = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);
    n_checks++; if ({ram_en_o, ram_we_o} !== 2'b10) $display("FAIL mid_inflight: got en=%b we=%b want 1/0", ram_en_o, ram_we_o); else n_pass++;
    next_cycle();
    rst_i = 1'b0; h_act = 1'b0; v_act = 1'b0;
    wr_log.delete();
    @(negedge clk_i);
    n_checks++; if ({disp_valid_o, fifo_level_o, ram_en_o} !== {1'b0, 3'd0, 1'b0})
      $display("FAIL mid_after: got v=%b lvl=%0d en=%b want 0/0/0", disp_valid_o, fifo_level_o, ram_en_o); else n_pass++;
    repeat (6) next_cycle();
    n_checks++; if (wr_log.size() != 0) $display("FAIL mid_no_write: got %0d writes want 0", wr_log.size()); else n_pass++;
  endtask

  // Random traffic compared cycle by cycle against the behavioural model
  task automatic test_random();
    logic exp_ready;
    apply_reset(2);
    idle_inputs();
    h_act = 1'b1; v_act = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) h_act = ~h_act;
      if ($urandom_range(0, 15) == 0) v_act = ~v_act;
      disp_req  = ($urandom_range(0, 99) < 45);
      disp_addr = AW'($urandom_range(0, 15));
      wv        = ($urandom_range(0, 99) < 70);
      waddr     = AW'($urandom_range(0, 15));
      wdata     = DW'($urandom);
      rst_i     = ($urandom_range(0, 199) == 0);
      @(negedge clk_i);
      exp_ready = !rst_i && (m_level < LW'(D));
      n_checks++;
      if ({ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, disp_valid_o, disp_data_o, fifo_level_o, host_wr_ready_o} !==
          {m_en, m_we, m_addr, m_wdata, m_valid, m_data, m_level, exp_ready})
        $display("FAIL rand c%0d: got en=%b we=%b a=%05h wd=%02h v=%b d=%02h lvl=%0d rdy=%b want en=%b we=%b a=%05h wd=%02h v=%b d=%02h lvl=%0d rdy=%b",
                 c, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, disp_valid_o, disp_data_o, fifo_level_o, host_wr_ready_o,
                 m_en, m_we, m_addr, m_wdata, m_valid, m_data, m_level, exp_ready);
      else n_pass++;
      next_cycle();
    end
    rst_i = 1'b0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_disp_latency();
    test_window_lockout();
    test_blanking_priority();
    test_full_backpressure();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
